// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register file and its clear sequencer.
package regfile_pkg;

  // Clear sequencer states: idle (accepting traffic) or sweeping zeroes.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every register index once, one per cycle, while
// holding ready low, then pulses clearDone on the final index.
import regfile_pkg::*;

module regfile_clear_fsm #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clearReq,
  output logic              ready,
  output logic              clearDone,
  output logic              sweepEn,
  output logic [ADDR_W-1:0] sweepIdx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  // State register and sweep counter; reset drops straight back to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and output decode; clearReq is only honoured while idle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    clearDone  = 1'b0;
    sweepEn    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (clearReq) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        sweepEn  = 1'b1;
        cnt_next = cnt + ADDR_W'(1);
        if (cnt == LAST_IDX) begin
          state_next = IDLE;
          clearDone  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sweepIdx = cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two bypassed read ports, one write port,
// a per-register busy scoreboard and a multi-cycle clear sweep.
// Optional: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] destReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] srcRegA,
  input  logic [ADDR_W-1:0] srcRegB,
  output logic [DATA_W-1:0] outBusA,
  output logic [DATA_W-1:0] outBusB,
  output logic              busyA,
  output logic              busyB,
  input  logic              rsvEn,
  input  logic [ADDR_W-1:0] rsvReg,
  input  logic              clearReq,
  output logic              ready,
  output logic              clearDone
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              sweepEn;
  logic [ADDR_W-1:0] sweepIdx;
  logic              wr_en, rsv_en, hit_a, hit_b;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clearReq  (clearReq),
    .ready     (ready),
    .clearDone (clearDone),
    .sweepEn   (sweepEn),
    .sweepIdx  (sweepIdx)
  );

  // Traffic is accepted only while idle; a hardwired zero register drops index 0.
  assign wr_en  = ready && regWrite && !(ZERO_REG && destReg == '0);
  assign rsv_en = ready && rsvEn && !(ZERO_REG && rsvReg == '0);
  assign hit_a  = wr_en && (destReg == srcRegA);
  assign hit_b  = wr_en && (destReg == srcRegB);

  // Storage and scoreboard update; a reserve is applied after the write so
  // the new producer wins when both target the same index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
      busy <= '0;
    end else if (sweepEn) begin
      regs[sweepIdx] <= '0;
      busy[sweepIdx] <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[destReg] <= writeData;
        busy[destReg] <= 1'b0;
      end
      if (rsv_en) begin
        busy[rsvReg] <= 1'b1;
      end
    end
  end

  // Combinational read ports with same-cycle write bypass.
  always_comb begin
    outBusA = hit_a ? writeData : regs[srcRegA];
    outBusB = hit_b ? writeData : regs[srcRegB];
    busyA   = busy[srcRegA] && !hit_a;
    busyB   = busy[srcRegB] && !hit_b;
    if (ZERO_REG && srcRegA == '0) begin
      outBusA = '0;
      busyA   = 1'b0;
    end
    if (ZERO_REG && srcRegB == '0) begin
      outBusB = '0;
      busyB   = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table,
// hand-written sweep/reset sequences and randomized traffic vs a model.
module tb_regfile_scoreboard;

  localparam int DEPTH = 16;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite, rsvEn, clearReq;
  logic [3:0]  destReg, srcRegA, srcRegB, rsvReg;
  logic [15:0] writeData, outBusA, outBusB;
  logic        busyA, busyB, ready, clearDone;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain arrays plus a sweep position.
  logic [15:0] mReg [DEPTH];
  bit          mBusy [DEPTH];
  bit          mSweeping;
  int          mPos;

  typedef struct {
    logic        regWrite;
    logic [3:0]  dest;
    logic [15:0] wd;
    logic [3:0]  srcA;
    logic        rsvEn;
    logic [3:0]  rsvReg;
    logic [15:0] expA;
    logic        expBusyA;
  } vec_t;

  vec_t vecs [11];

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .destReg   (destReg),
    .writeData (writeData),
    .srcRegA   (srcRegA),
    .srcRegB   (srcRegB),
    .outBusA   (outBusA),
    .outBusB   (outBusB),
    .busyA     (busyA),
    .busyB     (busyB),
    .rsvEn     (rsvEn),
    .rsvReg    (rsvReg),
    .clearReq  (clearReq),
    .ready     (ready),
    .clearDone (clearDone)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mReg[i]  = '0;
      mBusy[i] = 1'b0;
    end
    mSweeping = 1'b0;
    mPos      = 0;
  endtask

  // Expected read value for one port, from the rules of the register file.
  function automatic logic [15:0] modelRead(input logic [3:0] src);
    bit wr;
    wr = !mSweeping && regWrite && !(ZERO_REG && destReg == 0);
    if (ZERO_REG && src == 0) return 16'h0;
    if (wr && destReg == src) return writeData;
    return mReg[src];
  endfunction

  function automatic bit modelBusy(input logic [3:0] src);
    bit wr;
    wr = !mSweeping && regWrite && !(ZERO_REG && destReg == 0);
    if (ZERO_REG && src == 0) return 1'b0;
    return mBusy[src] && !(wr && destReg == src);
  endfunction

  task automatic checkOutput();
    checkVal("outBusA", outBusA, modelRead(srcRegA));
    checkVal("outBusB", outBusB, modelRead(srcRegB));
    checkVal("busyA", busyA, modelBusy(srcRegA));
    checkVal("busyB", busyB, modelBusy(srcRegB));
    checkVal("ready", ready, !mSweeping);
    checkVal("clearDone", clearDone, mSweeping && mPos == DEPTH - 1);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelClock();
    if (mSweeping) begin
      mReg[mPos]  = '0;
      mBusy[mPos] = 1'b0;
      mPos++;
      if (mPos == DEPTH) mSweeping = 1'b0;
    end else begin
      if (regWrite && !(ZERO_REG && destReg == 0)) begin
        mReg[destReg]  = writeData;
        mBusy[destReg] = 1'b0;
      end
      if (rsvEn && !(ZERO_REG && rsvReg == 0)) mBusy[rsvReg] = 1'b1;
      if (clearReq) begin
        mSweeping = 1'b1;
        mPos      = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [3:0] dst, input logic [15:0] wd,
                               input logic [3:0] sa, input logic [3:0] sb,
                               input logic rsv, input logic [3:0] rr, input logic clr);
    regWrite  = rw;
    destReg   = dst;
    writeData = wd;
    srcRegA   = sa;
    srcRegB   = sb;
    rsvEn     = rsv;
    rsvReg    = rr;
    clearReq  = clr;
  endtask

  // Entered at posedge+1: check mid-cycle, then clock DUT and model.
  task automatic stepCycle();
    #2;
    checkOutput();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  int lowCount, doneAt, doneCount;
  bit finished;

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    @(posedge clk);
    #1;
    checkVal("reset_ready", ready, 1'b1);
    checkVal("reset_clearDone", clearDone, 1'b0);
    checkVal("reset_outBusA", outBusA, 16'h0);
    checkVal("reset_busyA", busyA, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: bypass, scoreboard, collision and index-0 behaviour.
    vecs[0]  = '{0, 4'd0, 16'h0000, 4'd0, 0, 4'd0, 16'h0000, 0};
    vecs[1]  = '{1, 4'd3, 16'hA5A5, 4'd3, 0, 4'd0, 16'hA5A5, 0};
    vecs[2]  = '{0, 4'd3, 16'h0000, 4'd3, 0, 4'd0, 16'hA5A5, 0};
    vecs[3]  = '{0, 4'd0, 16'h0000, 4'd5, 1, 4'd5, 16'h0000, 0};
    vecs[4]  = '{0, 4'd0, 16'h0000, 4'd5, 0, 4'd0, 16'h0000, 1};
    vecs[5]  = '{1, 4'd5, 16'h1234, 4'd5, 0, 4'd0, 16'h1234, 0};
    vecs[6]  = '{0, 4'd0, 16'h0000, 4'd5, 0, 4'd0, 16'h1234, 0};
    vecs[7]  = '{1, 4'd7, 16'h0042, 4'd7, 1, 4'd7, 16'h0042, 0};
    vecs[8]  = '{0, 4'd0, 16'h0000, 4'd7, 0, 4'd0, 16'h0042, 1};
    vecs[9]  = '{1, 4'd0, 16'hFFFF, 4'd0, 1, 4'd0, ZERO_REG ? 16'h0000 : 16'hFFFF, 0};
    vecs[10] = '{0, 4'd1, 16'h0000, 4'd0, 0, 4'd0, ZERO_REG ? 16'h0000 : 16'hFFFF, !ZERO_REG};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].regWrite, vecs[i].dest, vecs[i].wd, vecs[i].srcA, vecs[i].dest,
                    vecs[i].rsvEn, vecs[i].rsvReg, 1'b0);
      #2;
      checkVal($sformatf("vec%0d_outBusA", i), outBusA, vecs[i].expA);
      checkVal($sformatf("vec%0d_busyA", i), busyA, vecs[i].expBusyA);
      #1;
      checkOutput();
      @(posedge clk);
      modelClock();
      #1;
    end

    // Clear sweep: fill, request clear (with a same-cycle write), try a mid-sweep write.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 4'(i), 16'h1000 + 16'(i) * 16'h0111, 4'(i), 4'(i), 0, 0, 0);
      stepCycle();
    end
    applyStimulus(1, 4'd9, 16'h9999, 4'd9, 4'd2, 0, 0, 1);
    stepCycle();
    lowCount  = 0;
    doneAt    = 0;
    doneCount = 0;
    finished  = 1'b0;
    for (int k = 0; k < 40 && !finished; k++) begin
      if (k == 5) applyStimulus(1, 4'd2, 16'hBEEF, 4'd2, 4'd9, 1, 4'd2, 1);
      else        applyStimulus(0, 4'd0, 16'h0, 4'(k), 4'd2, 0, 0, 0);
      #2;
      checkOutput();
      if (ready) begin
        finished = 1'b1;
      end else begin
        lowCount++;
        if (clearDone) begin
          doneCount++;
          doneAt = lowCount;
        end
        @(posedge clk);
        modelClock();
        #1;
      end
    end
    checkVal("sweep_finished", finished, 1'b1);
    checkVal("sweep_len", lowCount, 16);
    checkVal("clearDone_cycle", doneAt, 16);
    checkVal("clearDone_count", doneCount, 1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 0, 4'(i), 4'(15 - i), 0, 0, 0);
      #2;
      checkVal($sformatf("post_sweep_reg%0d", i), outBusA, 16'h0);
      #1;
      @(posedge clk);
      modelClock();
      #1;
    end

    // Reset in the sixth sweep cycle: immediate idle, everything cleared, no pulse.
    applyStimulus(1, 4'd12, 16'hCAFE, 4'd12, 4'd12, 1, 4'd13, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 4'd12, 4'd13, 0, 0, 1);
    stepCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 4'd12, 4'd13, 0, 0, 0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 4'd12, 4'd13, 0, 0, 0);
    #1;
    checkVal("pre_reset_ready", ready, 1'b0);
    reset = 1'b1;
    #1;
    modelReset();
    checkVal("midreset_ready", ready, 1'b1);
    checkVal("midreset_clearDone", clearDone, 1'b0);
    checkVal("midreset_reg12", outBusA, 16'h0);
    checkVal("midreset_busy13", busyB, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 4'(12 + k), 4'(k), 0, 0, 0);
      stepCycle();
    end

    // Randomized traffic against the model, with occasional clear requests.
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 1), 4'($urandom_range(0, 15)), 16'($urandom),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 39) == 0);
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-ported register file for the datapath, generalising the fixed 16x16 file.
- DATA_W-bit registers, 2**ADDR_W entries, two combinational read ports.
- One write port with same-cycle write-to-read bypass.
- Per-register busy scoreboard for hazard detection.
- Multi-cycle clear sequencer that zeroes the file without asserting reset.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register index width; DEPTH = 2**ADDR_W entries

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
regWrite  in  1  write enable
destReg  in  ADDR_W  write index
writeData  in  DATA_W  write data
srcRegA  in  ADDR_W  read index, port A
srcRegB  in  ADDR_W  read index, port B
outBusA  out  DATA_W  read data, port A
outBusB  out  DATA_W  read data, port B
busyA  out  1  scoreboard bit of srcRegA
busyB  out  1  scoreboard bit of srcRegB
rsvEn  in  1  reserve request (mark destination busy)
rsvReg  in  ADDR_W  register to reserve
clearReq  in  1  start clear sweep
ready  out  1  high when IDLE; writes and reservations accepted
clearDone  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (async, active-high):
  - All registers = 0, all busy bits = 0.
  - FSM = IDLE, sweep counter = 0.
  - Outputs: ready=1, clearDone=0, busyA=busyB=0, outBusA/B=0.
- Reads: combinational, zero latency.
  - Bypass: if ready && regWrite && destReg==srcRegA, then outBusA=writeData; otherwise outBusA=reg[srcRegA]. Port B identical.
- Write: when ready && regWrite, reg[destReg] <= writeData at the clock edge.
- Scoreboard:
  - When ready && rsvEn, busy[rsvReg] <= 1.
  - When ready && regWrite, busy[destReg] <= 0.
  - Reserve and write to the same index in the same cycle: busy ends 1 (new producer wins); the data is still written.
- busyA = busy[srcRegA] && !(ready && regWrite && destReg==srcRegA). busyB identical. A reserve becomes visible the cycle after it is issued.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when clearReq=1. The counter is loaded to 0 on entry. Any regWrite/rsvEn in that same cycle is still performed.
  - In SWEEP, each cycle: reg[cnt] <= 0, busy[cnt] <= 0, cnt++. ready=0. regWrite, rsvEn and clearReq are ignored (no effect, no queueing).
  - When cnt==DEPTH-1: write the last entry, go to IDLE, pulse clearDone=1 for exactly that cycle.
  - Sweep length: exactly DEPTH cycles with ready=0.
- Reads during SWEEP return current contents; there is no bypass of sweep zeroes, and write bypass is disabled.
- Counter wraps naturally at ADDR_W bits; no out-of-range index exists.
- Reset mid-sweep: immediate return to IDLE with everything cleared; clearDone is not pulsed.

Optional Feature:
REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero.
  - Writes to index 0 are dropped and reservations of index 0 are dropped.
  - busy[0] is constantly 0.
  - Reads of index 0 return 0, including when the write bypass would otherwise match.
- Undefined: index 0 is an ordinary register.

Decomposition:
- Shared package regfile_pkg:
  - FSM state typedef {IDLE, SWEEP}.
  - Default width constants DATA_W_DEF=16, ADDR_W_DEF=4.
- Sub-module regfile_clear_fsm owns the state register, sweep counter, ready and clearDone. It exports sweepEn and sweepIdx to the storage and scoreboard logic in the top.

Test Plan:
- Write then bypass: cycle 1 regWrite, destReg=3, writeData=16'hA5A5, srcRegA=3 -> outBusA=A5A5 in the same cycle. Cycle 2 with regWrite=0 -> outBusA=A5A5 from storage.
- Scoreboard: rsvEn rsvReg=5 -> busyA(src=5)=1 from the next cycle. Writing reg 5 -> busyA=0 combinationally in the write cycle and stays 0.
- Reserve/write collision on reg 7 with writeData=16'h0042 -> next cycle busy[7]=1 and reg7 reads 0042.
- Clear sweep with DEPTH=16: fill regs with nonzero values, pulse clearReq.
  - ready=0 for 16 cycles and clearDone high only on the 16th.
  - A regWrite to reg 2 mid-sweep is ignored.
  - All reads return 0 afterwards.
- Reset mid-sweep at cycle 6 -> ready=1 immediately, all regs and busy bits 0, no clearDone pulse.
- With REGFILE_ZERO_REG_EN: write 16'hFFFF to reg 0 and reserve reg 0 -> outBusA(src=0)=0 in the same and next cycle, busyA=0. Without the macro -> reads FFFF.
